// File: rtl/f_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// f_fetch_stage_pkg
//   Shared constants and types for the MIPS fetch stage and whatever instruction
//   memory sits behind it (word index = (F_PC - IM_BASE) >> 2).
//   PC_RESET : PC after reset
//   IM_BASE  : first byte address backed by instruction memory
//   IM_WORDS : instruction memory depth in words
//   NOP      : word substituted for an instruction whose fetch faulted
//   fd_t     : the F/D pipeline register contents
// -----------------------------------------------------------------------------
package f_fetch_stage_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 4096;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        exc_adel;
        logic        in_ds;
    } fd_t;

    // Fetch address error: misaligned, or outside base .. base+4*words-1.
    // The range test is done in 33 bits so a window ending at 2^32 still works.
    function automatic logic fetch_adel(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input int unsigned words);
        logic [32:0] p;
        logic [32:0] lo;
        logic [32:0] hi;
        p  = {1'b0, pc};
        lo = {1'b0, base};
        hi = lo + {1'b0, words[29:0], 2'b00};
        return (pc[1:0] != 2'b00) || (p < lo) || (p >= hi);
    endfunction

endpackage

// File: rtl/f_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// f_fetch_stage_if
//   Bundles the fetch stage's instruction-memory, hazard/CP0, decode and F/D
//   signals. The master modport is the fetch stage itself; slave is its
//   surroundings (imem, hazard unit, CP0, decode).
// -----------------------------------------------------------------------------
interface f_fetch_stage_if;

    logic [31:0] F_PC;
    logic [31:0] F_IM_instr;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        D_is_branch;
    logic [31:0] D_instr;
    logic [31:0] D_PC;
    logic        D_valid;
    logic        D_exc_adel;
    logic        D_in_ds;
    logic [31:0] fetch_cnt;

    modport master (
        output F_PC, D_instr, D_PC, D_valid, D_exc_adel, D_in_ds, fetch_cnt,
        input  F_IM_instr, stall, flush, flush_pc, redirect_en, redirect_pc,
               D_is_branch
    );

    modport slave (
        input  F_PC, D_instr, D_PC, D_valid, D_exc_adel, D_in_ds, fetch_cnt,
        output F_IM_instr, stall, flush, flush_pc, redirect_en, redirect_pc,
               D_is_branch
    );

endinterface

// File: rtl/f_fetch_stage_fd_pipe_reg.sv
// -----------------------------------------------------------------------------
// fd_pipe_reg
//   F/D pipeline register plus the fetched-instruction counter.
//   Priority per edge: flush (bubble) > stall (hold) > load (capture fd_in).
//   clk, reset     : clock, asynchronous active-low reset
//   flush/stall/load : register controls
//   fd_in          : next F/D contents from the fetch logic
//   fd_out         : current F/D contents
//   fetch_cnt      : number of load edges since reset (wraps at 2^32)
// -----------------------------------------------------------------------------
module fd_pipe_reg
    import f_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  fd_t         fd_in,
    output fd_t         fd_out,
    output logic [31:0] fetch_cnt
);

    fd_t         fd_q, fd_d;
    logic [31:0] cnt_q, cnt_d;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        fd_d  = fd_q;
        cnt_d = cnt_q;
        if (flush) begin
            fd_d = '{instr: NOP, pc: 32'h0, valid: 1'b0, exc_adel: 1'b0, in_ds: 1'b0};
        end else if (stall) begin
            fd_d = fd_q;
        end else if (load) begin
            fd_d  = fd_in;
            cnt_d = cnt_q + 32'd1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd_q  <= '0;
            cnt_q <= '0;
        end else begin
            fd_q  <= fd_d;
            cnt_q <= cnt_d;
        end
    end

    assign fd_out    = fd_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: rtl/f_fetch_stage.sv
// -----------------------------------------------------------------------------
// f_fetch_stage
//   Fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection
//   (flush > stall > redirect > PC+4), fetch address error check, and the F/D
//   register (fd_pipe_reg).
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : f_fetch_stage_if.master -- F_PC/F_IM_instr to imem, stall/flush/
//           redirect controls in, D_* F/D outputs and fetch_cnt out
// -----------------------------------------------------------------------------
module f_fetch_stage #(
    parameter logic [31:0] PC_RESET = f_fetch_stage_pkg::PC_RESET,
    parameter logic [31:0] IM_BASE  = f_fetch_stage_pkg::IM_BASE,
    parameter int unsigned IM_WORDS = f_fetch_stage_pkg::IM_WORDS
) (
    input  logic            clk,
    input  logic            reset,
    f_fetch_stage_if.master bus
);

    import f_fetch_stage_pkg::*;

    logic [31:0] pc_q, pc_d;
    logic        adel;
    logic        load;
    fd_t         fd_in;
    fd_t         fd_out;

    // A redirect needs no flush: the delay-slot instruction is the one in F
    // right now and is captured on the same edge the PC jumps.
    always_comb begin
        pc_d = pc_q;
        if (bus.flush) begin
            pc_d = bus.flush_pc;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.redirect_en) begin
            pc_d = bus.redirect_pc;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A faulting fetch still advances and loads; the NOP keeps garbage out of
    // decode until CP0 flushes on the exception flag.
    assign adel = fetch_adel(pc_q, IM_BASE, IM_WORDS);
    assign load = !bus.flush && !bus.stall;

    always_comb begin
        fd_in.instr    = adel ? NOP : bus.F_IM_instr;
        fd_in.pc       = pc_q;
        fd_in.valid    = 1'b1;
        fd_in.exc_adel = adel;
        fd_in.in_ds    = bus.D_is_branch;
    end

    fd_pipe_reg u_fd_pipe_reg (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .stall     (bus.stall),
        .load      (load),
        .fd_in     (fd_in),
        .fd_out    (fd_out),
        .fetch_cnt (bus.fetch_cnt)
    );

    assign bus.F_PC       = pc_q;
    assign bus.D_instr    = fd_out.instr;
    assign bus.D_PC       = fd_out.pc;
    assign bus.D_valid    = fd_out.valid;
    assign bus.D_exc_adel = fd_out.exc_adel;
    assign bus.D_in_ds    = fd_out.in_ds;

endmodule

// File: tb/tb_f_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_f_fetch_stage
//   Directed vector table for the documented scenarios, an asynchronous
//   mid-cycle reset, then randomized control traffic against a reference model.
// -----------------------------------------------------------------------------
module tb_f_fetch_stage;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          WORDS = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    f_fetch_stage_if bus ();

    f_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [31:0] im [WORDS];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic tb_bad(input logic [31:0] pc);
        longint p;
        p = longint'(pc);
        return (pc[1:0] != 2'b00) || (p < longint'(BASE)) ||
               (p >= longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic logic [11:0] tb_idx(input logic [31:0] pc);
        logic [31:0] o;
        o = (pc - BASE) >> 2;
        return o[11:0];
    endfunction

    // Instruction memory answers combinationally; unbacked addresses return
    // junk so a missing NOP substitution is visible.
    always_comb begin
        if (tb_bad(bus.F_PC)) bus.F_IM_instr = 32'hDEAD_BEEF;
        else                  bus.F_IM_instr = im[tb_idx(bus.F_PC)];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag,
                             input logic [31:0] fpc, input logic [31:0] dpc,
                             input logic [31:0] instr, input logic valid,
                             input logic adel, input logic ds,
                             input logic [31:0] cnt);
        check({tag, "_fpc"},   bus.F_PC,              fpc);
        check({tag, "_dpc"},   bus.D_PC,              dpc);
        check({tag, "_instr"}, bus.D_instr,           instr);
        check({tag, "_valid"}, 32'(bus.D_valid),      32'(valid));
        check({tag, "_adel"},  32'(bus.D_exc_adel),   32'(adel));
        check({tag, "_ds"},    32'(bus.D_in_ds),      32'(ds));
        check({tag, "_cnt"},   bus.fetch_cnt,         cnt);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_instr, m_dpc, m_cnt;
    logic        m_valid, m_adel, m_ds;

    task automatic m_reset();
        m_pc = BASE; m_instr = 0; m_dpc = 0; m_cnt = 0;
        m_valid = 0; m_adel = 0; m_ds = 0;
    endtask

    // What the next rising edge should do, given the inputs now on the bus.
    task automatic m_step();
        logic bad;
        if (bus.flush) begin
            m_pc = bus.flush_pc;
            m_instr = 0; m_dpc = 0; m_valid = 0; m_adel = 0; m_ds = 0;
        end else if (!bus.stall) begin
            bad     = tb_bad(m_pc);
            m_instr = bad ? 32'h0 : im[tb_idx(m_pc)];
            m_dpc   = m_pc;
            m_valid = 1'b1;
            m_adel  = bad;
            m_ds    = bus.D_is_branch;
            m_cnt   = m_cnt + 1;
            m_pc    = bus.redirect_en ? bus.redirect_pc : m_pc + 4;
        end
    endtask

    function automatic logic [31:0] rand_target();
        int unsigned k;
        logic [31:0] t;
        k = $urandom_range(0, 9);
        case (k)
            0:       t = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
            1:       t = 32'hFFFF_FFFC;
            2:       t = 32'($urandom_range(0, 32'h2FFF)) & ~32'h3;
            3:       t = 32'h0000_6FF0 + 32'(4 * $urandom_range(0, 7));
            default: t = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        endcase
        return t;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] flush_pc;
        logic        redir;
        logic [31:0] redir_pc;
        logic        br;
        logic [31:0] e_fpc;
        logic [31:0] e_dpc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_adel;
        logic        e_ds;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic drive(input logic st, input logic fl, input logic [31:0] fpc,
                         input logic rd, input logic [31:0] rpc, input logic br);
        bus.stall = st; bus.flush = fl; bus.flush_pc = fpc;
        bus.redirect_en = rd; bus.redirect_pc = rpc; bus.D_is_branch = br;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WORDS; i++) im[i] = 32'hA500_0000 | 32'(i);

        //            st  fl  flush_pc      rd  redir_pc      br   F_PC          D_PC          D_instr       v  ae ds cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h3004, 32'h3000, 32'hA500_0000, 1'b1, 1'b0, 1'b0, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h3008, 32'h3004, 32'hA500_0001, 1'b1, 1'b0, 1'b0, 32'd2};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h3100,  1'b0, 32'h3008, 32'h3004, 32'hA500_0001, 1'b1, 1'b0, 1'b0, 32'd2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h3100,  1'b0, 32'h3008, 32'h3004, 32'hA500_0001, 1'b1, 1'b0, 1'b0, 32'd2};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h300C, 32'h3008, 32'hA500_0002, 1'b1, 1'b0, 1'b0, 32'd3};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h3100,  1'b1, 32'h3100, 32'h300C, 32'hA500_0003, 1'b1, 1'b0, 1'b1, 32'd4};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h3104, 32'h3100, 32'hA500_0040, 1'b1, 1'b0, 1'b0, 32'd5};
        vecs[7]  = '{1'b1, 1'b1, 32'h4180,  1'b1, 32'h3200,  1'b1, 32'h4180, 32'h0,    32'h0,         1'b0, 1'b0, 1'b0, 32'd5};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h4184, 32'h4180, 32'hA500_0460, 1'b1, 1'b0, 1'b0, 32'd6};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h3002,  1'b0, 32'h3002, 32'h4184, 32'hA500_0461, 1'b1, 1'b0, 1'b0, 32'd7};
        vecs[10] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h7000,  1'b0, 32'h7000, 32'h3002, 32'h0,         1'b1, 1'b1, 1'b0, 32'd8};
        vecs[11] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h6FFC,  1'b0, 32'h6FFC, 32'h7000, 32'h0,         1'b1, 1'b1, 1'b0, 32'd9};
        vecs[12] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h7000, 32'h6FFC, 32'hA500_0FFF, 1'b1, 1'b0, 1'b0, 32'd10};
        vecs[13] = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 32'h7004, 32'h7000, 32'h0,         1'b1, 1'b1, 1'b0, 32'd11};

        // Reset held across a clock edge: state must stay at reset values.
        #7;
        check_all("reset", 32'h3000, 0, 0, 0, 0, 0, 0);
        #5 reset = 1'b1;   // released at t=12, between edges

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].flush_pc,
                  vecs[i].redir, vecs[i].redir_pc, vecs[i].br);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_fpc, vecs[i].e_dpc,
                      vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_adel,
                      vecs[i].e_ds, vecs[i].e_cnt);
        end

        // Asynchronous reset mid-cycle while stalled: clears before any edge.
        drive(1, 0, 0, 0, 0, 0);
        #3 reset = 1'b0;
        #1;
        check_all("async_rst", 32'h3000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        m_reset();

        // Randomized control traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                  rand_target(), $urandom_range(0, 5) == 0, rand_target(),
                  $urandom_range(0, 3) == 0);
            m_step();
            @(posedge clk);
            #1;
            check_all("rnd", m_pc, m_dpc, m_instr, m_valid, m_adel, m_ds, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
